fifo_rd_checker: RTL
====================

# fifo_rd_checker

Read-domain stream checker that sits directly downstream of `fifo_wrapper`, on the FIFO read port. It watches every word popped from the FIFO and compares it against a local LFSR model of the write-side pseudo-random generator. It reports word and error counts, a sticky error flag, the first mismatching pair and a stall watchdog, so a hardware run can prove the FIFO is loss-free without a logic analyser.

## Interface
- `DATA_LEN`, 8: data width; must match the FIFO.
- `TAPS`, 8'hB8: LFSR feedback mask, identical to the write-side generator.
- `SEED`, 8'h01: LFSR start value, used when `SELF_SYNC`=0.
- `SELF_SYNC`, 0: 1 = first received word seeds the model; 0 = model starts at `SEED`.
- `CNT_LEN`, 16: width of word and error counters.
- `TIMEOUT`, 1024: idle read-clock cycles in RUN before `stall_o` asserts; must be ≥ 2.
- `clk` in 1: read-domain clock, single clock for the block.
- `rst_n` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous restart; returns the block to its reset state.
- `read_en` in 1: FIFO read strobe as driven to `fifo_wrapper` (already gated by not-empty).
- `rdata_i` in DATA_LEN: FIFO `rdata_o`.
- `word_cnt_o` out CNT_LEN: words checked, saturating.
- `err_cnt_o` out CNT_LEN: mismatches, saturating.
- `err_o` out 1: sticky, set on the first mismatch.
- `stall_o` out 1: sticky watchdog flag.
- `first_exp_o` out DATA_LEN: expected value at the first mismatch.
- `first_got_o` out DATA_LEN: received value at the first mismatch.

## Operation
- LFSR step: next(x) = {x[DATA_LEN-2:0], ^(x & TAPS)}.
- Defaults give 01, 02, 04, 08, 11, 23, …
- Word valid: `vld` = `read_en` delayed one cycle. The FIFO read is registered, so `rdata_i` is valid the cycle after `read_en`.
- FSM has two states: IDLE (no word checked yet) and RUN.
- IDLE, `SELF_SYNC`=0:
  - `exp` holds `SEED`.
  - On `vld`: compare `rdata_i` with `exp`, set `exp` to next(`exp`), go to RUN.
- IDLE, `SELF_SYNC`=1:
  - On `vld`: do not compare; set `exp` to next(`rdata_i`), set `word_cnt` to 1, go to RUN.
  - If `rdata_i`=0, also count it as an error, because the LFSR lock-up state is illegal.
- RUN: on every `vld`, compare `rdata_i` with `exp`, then set `exp` to next(`exp`).
  - The model always advances from the expected value, never from the received value.
  - So a single corrupted word costs one error, and a dropped or duplicated word produces a continuous error run.
- On every compared word, `word_cnt` increments by 1.
- On mismatch:
  - `err_cnt` increments by 1.
  - If `err_o`=0, capture `first_exp_o`/`first_got_o` and set `err_o`. Later mismatches never overwrite the capture.
- Both counters saturate at 2^CNT_LEN−1 and hold there; they never wrap.
- Watchdog runs in RUN only.
  - An idle counter clears on `vld` and increments otherwise.
  - When it reaches `TIMEOUT`, `stall_o` sets (sticky) and the counter holds.
  - In IDLE the counter is held at 0.
- `clr`: same effect as reset, but synchronous.
  - `clr` coinciding with `vld`: `clr` wins and the word is discarded.
  - `clr` coinciding with `read_en`: the delayed `vld` is also squashed.
- `rst_n` low at any time, including mid-stream:
  - All state returns immediately to the reset value.
  - A `vld` pending in the delay register is dropped.

## Timing
- Reset and `clr` values:
  - FSM = IDLE, `exp` = `SEED`.
  - `vld` = 0, idle counter = 0.
  - All outputs = 0.
- Latency:
  - `read_en` at cycle n → data compared at n+1.
  - Counters, `err_o` and first-mismatch capture are registered and visible at n+2.
- Throughput: one word per cycle. Back-to-back `read_en` must be checked with no bubbles.
- `stall_o` rises on the cycle the idle counter reaches `TIMEOUT`, i.e. `TIMEOUT` cycles after the last `vld`.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

## Test plan
- **Clean stream:** `SELF_SYNC`=0, feed 01,02,04,08,11,23 back-to-back one cycle after each `read_en`.
  - Required: `word_cnt_o`=6, `err_cnt_o`=0, `err_o`=0.
- **Single corruption:** same stream with the 4th word replaced by 0x09.
  - Required: `err_cnt_o`=1, `first_exp_o`=0x08, `first_got_o`=0x09.
  - The following words 11,23 must still pass.
- **Dropped word:** feed 01,02,08,11,23.
  - Required: `err_cnt_o`=3, `first_exp_o`=0x04, `first_got_o`=0x08, `word_cnt_o`=5.
- **Self-sync:** `SELF_SYNC`=1, first word 0x11, then 23,…
  - Required: no errors, `word_cnt_o` matches the words sent.
  - First word 0x00 instead: `err_cnt_o`=1.
- **Watchdog:** `TIMEOUT`=16, send one word, then no `read_en`.
  - Required: `stall_o` rises exactly 16 cycles after that `vld`.
  - A `vld` before 16 cycles prevents `stall_o`.
- **Reset and clear mid-stream:**
  - Assert `rst_n`=0 asynchronously with `read_en` pending: all outputs 0 at once, and the pending word is not counted.
  - Pulse `clr` with `vld`: the word is discarded and the next word is checked against `SEED`.
  - Counter saturation with `CNT_LEN`=3 and 10 errors: `err_cnt_o` holds at 7.

Source files
------------

// File: rtl/fifo_rd_checker.sv
// fifo_rd_checker: read-side stream checker for fifo_wrapper.
// Compares each popped word with a local LFSR model of the write-side
// generator. It reports word/error counts, a sticky error flag with a
// capture of the first mismatch, and a stall watchdog.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | no word checked yet; exp holds SEED (or awaits self-sync)
//   S_RUN  | checking every valid word; watchdog active
module fifo_rd_checker #(
  parameter int                  DATA_LEN  = 8,
  parameter logic [DATA_LEN-1:0] TAPS      = DATA_LEN'(8'hB8),
  parameter logic [DATA_LEN-1:0] SEED      = DATA_LEN'(8'h01),
  parameter bit                  SELF_SYNC = 1'b0,
  parameter int                  CNT_LEN   = 16,
  parameter int                  TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                read_en,
  input  logic [DATA_LEN-1:0] rdata_i,
  output logic [CNT_LEN-1:0]  word_cnt_o,
  output logic [CNT_LEN-1:0]  err_cnt_o,
  output logic                err_o,
  output logic                stall_o,
  output logic [DATA_LEN-1:0] first_exp_o,
  output logic [DATA_LEN-1:0] first_got_o
);

  localparam int                 IDLE_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0]  IDLE_TO = IDLE_W'(TIMEOUT);
  localparam logic [IDLE_W-1:0]  IDLE_PRE = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_LEN-1:0] CNT_MAX = '1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              state;
  logic                vld;
  logic [DATA_LEN-1:0] exp_q;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                sync_word;
  logic                mismatch;
  logic                seed_zero;
  logic                bump_err;

  function automatic logic [DATA_LEN-1:0] lfsr_next(input logic [DATA_LEN-1:0] x);
    return {x[DATA_LEN-2:0], ^(x & TAPS)};
  endfunction

  // Classify the word on the read port: seeding word, mismatch, or illegal zero seed.
  always_comb begin
    sync_word = 1'b0;
    mismatch  = 1'b0;
    seed_zero = 1'b0;
    if (vld) begin
      if (SELF_SYNC && (state == S_IDLE)) begin
        sync_word = 1'b1;
        seed_zero = (rdata_i == '0);
      end else begin
        mismatch = (rdata_i != exp_q);
      end
    end
    bump_err = mismatch | seed_zero;
  end

  // Word-valid delay; clr squashes a read issued in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= 1'b0;
    else        vld <= read_en & ~clr;
  end

  // FSM and LFSR model; the model always advances from the expected value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      exp_q <= SEED;
    end else if (clr) begin
      state <= S_IDLE;
      exp_q <= SEED;
    end else if (vld) begin
      state <= S_RUN;
      exp_q <= sync_word ? lfsr_next(rdata_i) : lfsr_next(exp_q);
    end
  end

  // Saturating counters, sticky error flag and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_cnt_o  <= '0;
      err_cnt_o   <= '0;
      err_o       <= 1'b0;
      first_exp_o <= '0;
      first_got_o <= '0;
    end else if (clr) begin
      word_cnt_o  <= '0;
      err_cnt_o   <= '0;
      err_o       <= 1'b0;
      first_exp_o <= '0;
      first_got_o <= '0;
    end else if (vld) begin
      if (word_cnt_o != CNT_MAX) word_cnt_o <= word_cnt_o + 1'b1;
      if (bump_err) begin
        if (err_cnt_o != CNT_MAX) err_cnt_o <= err_cnt_o + 1'b1;
        if (!err_o) begin
          err_o       <= 1'b1;
          first_exp_o <= exp_q;
          first_got_o <= rdata_i;
        end
      end
    end
  end

  // Stall watchdog: counts idle cycles in RUN, raises stall_o with the terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      stall_o  <= 1'b0;
    end else if (clr) begin
      idle_cnt <= '0;
      stall_o  <= 1'b0;
    end else if (state == S_RUN) begin
      if (vld) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_TO) begin
        idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == IDLE_PRE) stall_o <= 1'b1;
      end
    end
  end

endmodule
